// File: rtl/if_fetch_pkg.sv
// Shared constants for the instruction-fetch stage: FSM state encodings,
// queue depth and sequential PC increment.
package if_fetch_pkg;

  localparam logic [0:0] IF_ST_FETCH = 1'b0;
  localparam logic [0:0] IF_ST_HALT  = 1'b1;

  localparam int unsigned IF_QUEUE_DEPTH = 2;
  localparam int unsigned IF_PC_INC      = 4;

  // Occupancy counters are 2 bits wide (0..IF_QUEUE_DEPTH)
  localparam logic [1:0] IF_QUEUE_DEPTH_W = 2'(IF_QUEUE_DEPTH);

endpackage

// File: rtl/if_queue.sv
// Two-entry FIFO of {pc, instr} records with synchronous clear; head data
// reads as zero when the queue is empty.
module if_queue
  import if_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] entry [IF_QUEUE_DEPTH];
  logic [1:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt != IF_QUEUE_DEPTH_W) begin
            entry[cnt[0]] <= push_data;
            cnt           <= cnt + 2'd1;
          end
        end
        2'b01: begin
          entry[0] <= entry[1];
          cnt      <= cnt - 2'd1;
        end
        2'b11: begin
          // Simultaneous pop and push keeps the count; the new record lands
          // behind whatever survives the pop.
          if (cnt == 2'd1) begin
            entry[0] <= push_data;
          end else begin
            entry[0] <= entry[1];
            entry[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign count     = cnt;
  assign head_data = (cnt != 2'd0) ? entry[0] : '0;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: sequential word fetch, 2-entry instruction queue,
// redirect flush and halt. Define IF_FETCH_CNT_EN to add fetch/flush counters.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int unsigned       WORD_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [WORD_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_en,
  output logic [WORD_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [WORD_W-1:0]  if_pc,
  input  logic               id_ready,
  input  logic               redirect_valid,
  input  logic [WORD_W-1:0]  redirect_pc,
  input  logic               halt
`ifdef IF_FETCH_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        flush_cnt
`endif
);

  logic [0:0]                state;
  logic [WORD_W-1:0]         pc;
  logic                      inflight;
  logic [WORD_W-1:0]         inflight_pc;
  logic [1:0]                q_count;
  logic [WORD_W+INSTR_W-1:0] q_head;
  logic                      take;
  logic                      pop;
  logic                      push;
  logic                      issue;
  logic [2:0]                occupancy;
  logic                      unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign if_valid = (q_count != 2'd0);
  assign take     = if_valid && id_ready;
  assign pop      = take && !redirect_valid;
  assign push     = inflight && !redirect_valid && !rst;

  // Space after this cycle's pop must cover everything already in flight,
  // so a response is never dropped for lack of room.
  assign occupancy = {1'b0, q_count} - {2'b00, take} + {2'b00, inflight};
  assign issue     = !rst && (state == IF_ST_FETCH) && !redirect_valid && !halt &&
                     (occupancy < {1'b0, IF_QUEUE_DEPTH_W});

  assign imem_en   = issue;
  assign imem_addr = pc;

  if_queue #(
    .WIDTH (WORD_W + INSTR_W)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clr       (redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, imem_rdata}),
    .pop       (pop),
    .head_data (q_head),
    .count     (q_count)
  );

  assign {if_pc, if_instr} = q_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IF_ST_FETCH;
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      state       <= IF_ST_FETCH;
      pc          <= {redirect_pc[WORD_W-1:2], 2'b00};
      inflight    <= 1'b0;
    end else begin
      if (state == IF_ST_FETCH && halt) begin
        state <= IF_ST_HALT;
      end
      inflight <= issue;
      if (issue) begin
        inflight_pc <= pc;
        pc          <= pc + WORD_W'(IF_PC_INC);
      end
    end
  end

`ifdef IF_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      fetch_cnt <= fetch_cnt + 32'(issue);
      if (redirect_valid) begin
        flush_cnt <= flush_cnt + 32'(q_count) + 32'(inflight);
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed cycle table followed by a
// randomized run against a stream-level reference model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
`ifdef IF_FETCH_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] flush_cnt;
`endif

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic [31:0] key = '0;

  always #5 clk = ~clk;

  if_fetch #(
    .WORD_W   (32),
    .INSTR_W  (32),
    .RESET_PC (32'h0)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt)
`ifdef IF_FETCH_CNT_EN
    ,
    .fetch_cnt      (fetch_cnt),
    .flush_cnt      (flush_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ key;
  endfunction

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem_word(imem_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        hlt;
    logic        chk;
    logic        e_valid;
    logic [31:0] e_pc;
    logic        e_en;
    logic [31:0] e_addr;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                         input logic hlt, input logic chk, input logic ev, input logic [31:0] epc,
                         input logic een, input logic [31:0] eaddr);
    vec_t v;
    v.rst = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.hlt = hlt; v.chk = chk;
    v.e_valid = ev; v.e_pc = epc; v.e_en = een; v.e_addr = eaddr;
    tbl.push_back(v);
  endtask

  logic [31:0] exp_pc;
  logic [31:0] fetch_addr;
  logic [31:0] hold_pc;
  logic [31:0] hold_instr;
  bit          halted;
  bit          hold;
  int          idle;

  initial begin
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (2) @(posedge clk);

    // rst rdy rv rpc hlt chk | valid pc en addr   (memory word = address)
    add_row(1, 1, 0, 0, 0, 1,  0, 32'h0, 0, 32'h0);          // held in reset
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h0);          // c0
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h4);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h0, 1, 32'h8);          // c2 first valid
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h4, 1, 32'hC);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h8, 1, 32'h10);
    add_row(0, 0, 0, 0, 0, 1,  1, 32'hC, 0, 32'h14);         // c5 stall
    add_row(0, 0, 0, 0, 0, 1,  1, 32'hC, 0, 32'h14);
    add_row(0, 0, 0, 0, 0, 1,  1, 32'hC, 0, 32'h14);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'hC, 1, 32'h14);         // c8 release
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h10, 1, 32'h18);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h14, 1, 32'h1C);
    add_row(0, 1, 1, 32'h103, 0, 1, 1, 32'h18, 0, 32'h20);   // c11 redirect
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h100);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h104);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h100, 1, 32'h108);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h104, 1, 32'h10C);
    add_row(0, 1, 0, 0, 1, 1,  1, 32'h108, 0, 32'h110);      // c16 halt
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h10C, 0, 32'h110);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 0, 32'h110);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 0, 32'h110);
    add_row(0, 1, 1, 32'h40, 1, 1, 0, 32'h0, 0, 32'h110);    // redirect + halt
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h40);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h44);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h40, 1, 32'h48);
    add_row(0, 1, 1, 32'hFFFF_FFF8, 0, 1, 1, 32'h44, 0, 32'h4C);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'hFFFF_FFF8);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'hFFFF_FFFC);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'hFFFF_FFF8, 1, 32'h0);  // address wrap
    add_row(0, 1, 0, 0, 0, 1,  1, 32'hFFFF_FFFC, 1, 32'h4);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h0, 1, 32'h8);
    add_row(1, 1, 0, 0, 0, 0,  0, 32'h0, 0, 32'h0);          // mid-run reset
    add_row(1, 1, 0, 0, 0, 1,  0, 32'h0, 0, 32'h0);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h0);
    add_row(0, 1, 0, 0, 0, 1,  0, 32'h0, 1, 32'h4);
    add_row(0, 1, 0, 0, 0, 1,  1, 32'h0, 1, 32'h8);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = tbl[i].rst; id_ready = tbl[i].rdy; redirect_valid = tbl[i].rv;
      redirect_pc = tbl[i].rpc; halt = tbl[i].hlt;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
        check($sformatf("row%0d_pc", i), if_pc, tbl[i].e_pc);
        check($sformatf("row%0d_instr", i), if_instr, tbl[i].e_valid ? tbl[i].e_pc : 32'h0);
        check($sformatf("row%0d_en", i), 32'(imem_en), 32'(tbl[i].e_en));
        check($sformatf("row%0d_addr", i), imem_addr, tbl[i].e_addr);
      end
`ifdef IF_FETCH_CNT_EN
      if (i == 0) begin
        check("rst_fetch_cnt", fetch_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
      end
      if (i == 13) begin
        check("fetch_cnt", fetch_cnt, 32'd8);
        check("flush_cnt", flush_cnt, 32'd2);
      end
`endif
    end

    // Randomized run: accepted instructions must form the sequential stream
    // starting at the latest redirect target, fetches must follow the same
    // order, halt must silence fetching, stalls must hold outputs.
    key = $urandom;
    halted = 0; hold = 0; idle = 0; exp_pc = '0; fetch_addr = '0;
    hold_pc = '0; hold_instr = '0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst = 1'b0;
      id_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = (n == 0) || ($urandom_range(0, 99) < 3);
      redirect_pc = $urandom;
      halt = ($urandom_range(0, 99) < 3);
      #1;
      if (hold && !redirect_valid) begin
        check("stall_valid", 32'(if_valid), 32'd1);
        check("stall_pc", if_pc, hold_pc);
        check("stall_instr", if_instr, hold_instr);
      end
      if (redirect_valid) begin
        check("redirect_en", 32'(imem_en), 32'd0);
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
        fetch_addr = exp_pc;
        halted = 0;
        idle = 0;
      end else begin
        if (halted || halt) begin
          check("halt_en", 32'(imem_en), 32'd0);
        end else if (imem_en) begin
          check("fetch_addr", imem_addr, fetch_addr);
          fetch_addr = fetch_addr + 32'd4;
        end
        if (if_valid && id_ready) begin
          check("stream_pc", if_pc, exp_pc);
          check("stream_instr", if_instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          idle = 0;
        end else if (!halted && !halt && id_ready) begin
          idle++;
          if (idle > 2) check("progress_stuck", 32'(idle), 32'd2);
        end else begin
          idle = 0;
        end
        if (halt) halted = 1;
      end
      hold = if_valid && !id_ready && !redirect_valid;
      hold_pc = if_pc;
      hold_instr = if_instr;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
